// File: rtl/sprite_pixel_streamer_if.sv
// Request/pixel handshake bundle for sprite_pixel_streamer.
// Optional SPRITE_MIRROR_EN adds the req_mirror request qualifier.
interface sprite_pixel_streamer_if #(
    parameter int IMAGECOUNT      = 2,
    parameter int IMAGEWIDTH      = 16,
    parameter int IMAGEHEIGHT     = 16,
    parameter int IMAGEINDEXWIDTH = 1
);
    localparam int XW = $clog2(IMAGEWIDTH);
    localparam int YW = $clog2(IMAGEHEIGHT);

    logic [IMAGECOUNT*IMAGEWIDTH*IMAGEHEIGHT-1:0] image;
    logic                       req_valid;
    logic                       req_ready;
    logic [IMAGEINDEXWIDTH-1:0] req_index;
`ifdef SPRITE_MIRROR_EN
    logic                       req_mirror;
`endif
    logic                       pix_valid;
    logic                       pix_ready;
    logic                       pix_data;
    logic [XW-1:0]              pix_x;
    logic [YW-1:0]              pix_y;
    logic                       pix_last;
    logic                       done;
    logic                       err;

    modport master (
        output image, req_valid, req_index,
`ifdef SPRITE_MIRROR_EN
        output req_mirror,
`endif
        output pix_ready,
        input  req_ready, pix_valid, pix_data, pix_x, pix_y, pix_last, done, err
    );

    modport slave (
        input  image, req_valid, req_index,
`ifdef SPRITE_MIRROR_EN
        input  req_mirror,
`endif
        input  pix_ready,
        output req_ready, pix_valid, pix_data, pix_x, pix_y, pix_last, done, err
    );
endinterface

// File: rtl/sprite_pixel_streamer.sv
// Snapshots one sprite from a packed image bus and streams it row-major, one pixel per handshake.
// Optional horizontal flip via macro SPRITE_MIRROR_EN (adds req_mirror).
//
//   state  | meaning
//   IDLE   | req_ready high, waiting for a request
//   STREAM | pix_valid high, walking the snapshot pixel by pixel
module sprite_pixel_streamer #(
    parameter int IMAGECOUNT      = 2,
    parameter int IMAGEWIDTH      = 16,
    parameter int IMAGEHEIGHT     = 16,
    parameter int IMAGEINDEXWIDTH = 1
) (
    input  logic clock,
    input  logic reset_n,
    sprite_pixel_streamer_if.slave bus
);
    localparam int W   = IMAGEWIDTH;
    localparam int H   = IMAGEHEIGHT;
    localparam int PIX = W * H;
    localparam int XW  = $clog2(W);
    localparam int YW  = $clog2(H);
    localparam int BW  = $clog2(PIX);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [PIX-1:0] r_snap;
    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic           r_done;
    logic           r_err;
    logic           r_mirror;

    logic [PIX-1:0] w_sel;
    logic           w_hit;
    logic           w_acc;
    logic           w_pix_hs;
    logic           w_at_last;
    logic           w_mirror_req;
    logic [XW-1:0]  w_col;
    logic [BW-1:0]  w_bit;

`ifdef SPRITE_MIRROR_EN
    assign w_mirror_req = bus.req_mirror;
`else
    assign w_mirror_req = 1'b0;
`endif

    // An out-of-range index matches no sprite, leaving w_sel zero and w_hit low.
    always_comb begin
        w_sel = '0;
        w_hit = 1'b0;
        for (int i = 0; i < IMAGECOUNT; i++) begin
            if (bus.req_index == IMAGEINDEXWIDTH'(i)) begin
                w_sel = bus.image[i*PIX +: PIX];
                w_hit = 1'b1;
            end
        end
    end

    assign w_acc     = bus.req_valid && (r_state == IDLE);
    assign w_pix_hs  = (r_state == STREAM) && bus.pix_ready;
    assign w_at_last = (r_x == XW'(W - 1)) && (r_y == YW'(H - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_acc) w_next = STREAM;
            STREAM:  if (w_pix_hs && w_at_last) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_snap   <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_mirror <= 1'b0;
        end else begin
            r_done <= w_pix_hs && w_at_last;
            r_err  <= w_acc && !w_hit;
            if (w_acc) begin
                r_snap   <= w_sel;
                r_x      <= '0;
                r_y      <= '0;
                r_mirror <= w_mirror_req;
            end else if (w_pix_hs) begin
                if (r_x == XW'(W - 1)) begin
                    r_x <= '0;
                    r_y <= w_at_last ? '0 : r_y + 1'b1;
                end else begin
                    r_x <= r_x + 1'b1;
                end
            end
        end
    end

    // Column 0 is the row MSB unless the latched mirror flag flips the row.
    assign w_col = r_mirror ? r_x : (XW'(W - 1) - r_x);
    assign w_bit = BW'(r_y) * BW'(W) + BW'(w_col);

    assign bus.req_ready = (r_state == IDLE);
    assign bus.pix_valid = (r_state == STREAM);
    assign bus.pix_data  = (r_state == STREAM) && r_snap[w_bit];
    assign bus.pix_x     = r_x;
    assign bus.pix_y     = r_y;
    assign bus.pix_last  = (r_state == STREAM) && w_at_last;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule
